// File: rtl/enc_bin2gray_pkg.sv
// enc_bin2gray_pkg: shared constants and reference encode/decode functions
// for the binary-to-Gray encoder slice.
// Optional feature macro used by this slice: ENC_BIN2GRAY_CHECK_EN
package enc_bin2gray_pkg;

   // Default data width of the encoder; legal range is 1..64.
   localparam int ENC_WIDTH_DEFAULT = 12;

   // Widest word the helper functions handle.
   localparam int ENC_WIDTH_MAX = 64;

   // Reflected-binary encode. Narrower words are zero-extended by the
   // caller, so the upper zero bits leave the result unchanged.
   function automatic logic [ENC_WIDTH_MAX-1:0] bin2gray(
      input logic [ENC_WIDTH_MAX-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   // Reflected-binary decode: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
   // Zero-extended upper bits decode to zero and do not disturb the rest.
   function automatic logic [ENC_WIDTH_MAX-1:0] gray2bin(
      input logic [ENC_WIDTH_MAX-1:0] g
   );
      logic [ENC_WIDTH_MAX-1:0] b;
      b = '0;
      b[ENC_WIDTH_MAX-1] = g[ENC_WIDTH_MAX-1];
      for (int i = ENC_WIDTH_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// gray2bin_dec: purely combinational Gray-to-binary decoder, used by the
// round-trip checker in enc_bin_to_gray.
module gray2bin_dec
   import enc_bin2gray_pkg::*;
#(
   parameter int WIDTH = ENC_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   logic [WIDTH-1:0] w_bin;

   // Prefix-XOR from the MSB down: each binary bit is the parity of all
   // Gray bits at and above it.
   always_comb begin
      w_bin = '0;
      w_bin[WIDTH-1] = i_gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         w_bin[i] = w_bin[i+1] ^ i_gray[i];
      end
   end

   assign o_bin = w_bin;

endmodule

// File: rtl/enc_bin_to_gray.sv
// enc_bin_to_gray: registered binary-to-Gray encoder with one clock of
// latency. Optional round-trip self-check enabled by ENC_BIN2GRAY_CHECK_EN.
//
// Handshake: there is no back-pressure. A word is accepted on every rising
// edge where in_valid=1 and rst=0; its Gray code appears on gray after that
// edge with out_valid=1 for exactly one cycle. With in_valid=0, gray holds
// and out_valid is 0. rst wins over in_valid on the same edge.
module enc_bin_to_gray
   import enc_bin2gray_pkg::*;
#(
   parameter int WIDTH = ENC_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] bin,
   output logic             out_valid,
`ifdef ENC_BIN2GRAY_CHECK_EN
   output logic             chk_err,
`endif
   output logic [WIDTH-1:0] gray
);

   logic [WIDTH-1:0] w_gray_next;
   logic [WIDTH-1:0] r_gray;
   logic             r_out_valid;

   // Inline encoder: each Gray bit is the XOR of a binary bit and its
   // upper neighbour; the MSB passes through (bin >> 1 shifts in a zero).
   assign w_gray_next = bin ^ (bin >> 1);

   // Capture path: register the encoded word and its valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gray      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_gray <= w_gray_next;
         end
      end
   end

   assign gray      = r_gray;
   assign out_valid = r_out_valid;

`ifdef ENC_BIN2GRAY_CHECK_EN
   logic [WIDTH-1:0] r_bin_copy;
   logic [WIDTH-1:0] w_dec_bin;
   logic             r_chk_err;

   // Keep the binary word that produced r_gray, captured on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin_copy <= '0;
      end else if (in_valid) begin
         r_bin_copy <= bin;
      end
   end

   gray2bin_dec #(
      .WIDTH (WIDTH)
   ) u_dec (
      .i_gray (r_gray),
      .o_bin  (w_dec_bin)
   );

   // Sticky error: a decoded word that disagrees with its source during a
   // valid cycle flags chk_err on the following edge until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chk_err <= 1'b0;
      end else if (r_out_valid && (w_dec_bin != r_bin_copy)) begin
         r_chk_err <= 1'b1;
      end
   end

   assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_enc_bin_to_gray.sv
// tb_enc_bin_to_gray: directed bench for enc_bin_to_gray at WIDTH=12.
module tb_enc_bin_to_gray;

  localparam int W = 12;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] bin;
  logic         out_valid;
  logic [W-1:0] gray;
`ifdef ENC_BIN2GRAY_CHECK_EN
  logic         chk_err;
`endif

  int tests_run;
  int tests_failed;

  logic [W-1:0] exp_q[$];

  enc_bin_to_gray #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin       (bin),
    .out_valid (out_valid),
`ifdef ENC_BIN2GRAY_CHECK_EN
    .chk_err   (chk_err),
`endif
    .gray      (gray)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs away from the active edge, then sample 1 ns after it
  task automatic step(input logic r, input logic v, input logic [W-1:0] b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    bin      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_err_clear(input string tag);
`ifdef ENC_BIN2GRAY_CHECK_EN
    check(tag, W'(chk_err), W'(1'b0));
`endif
  endtask

  logic [W-1:0] sweep_exp [10];
  logic [W-1:0] prev_gray;
  logic [W-1:0] rb;
  logic [W-1:0] e;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b1;
    bin          = 12'hABC;

    sweep_exp = '{12'h000, 12'h001, 12'h003, 12'h002, 12'h006,
                  12'h007, 12'h005, 12'h004, 12'h00C, 12'h00D};

    // reset for two cycles with a valid word presented
    step(1'b1, 1'b1, 12'hABC);
    step(1'b1, 1'b1, 12'hABC);
    check("rst_gray", gray, 12'h000);
    check("rst_valid", W'(out_valid), W'(1'b0));
    check_err_clear("rst_chk_err");

    // zero and all-ones boundaries
    step(1'b0, 1'b1, 12'h000);
    check("zero_gray", gray, 12'h000);
    check("zero_valid", W'(out_valid), W'(1'b1));
    step(1'b0, 1'b1, 12'hFFF);
    check("ones_gray", gray, 12'h800);
    check("ones_valid", W'(out_valid), W'(1'b1));
    prev_gray = gray;

    // back-to-back sweep 0..9; first step also covers the FFF -> 000 wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, W'(i));
      check($sformatf("sweep_gray_%0d", i), gray, sweep_exp[i]);
      check($sformatf("sweep_1bit_%0d", i), W'($countones(gray ^ prev_gray)), W'(1));
      prev_gray = gray;
    end
    check("sweep_valid", W'(out_valid), W'(1'b1));

    // hold: bin changes with in_valid low
    step(1'b0, 1'b0, 12'h123);
    check("hold_gray", gray, 12'h00D);
    check("hold_valid", W'(out_valid), W'(1'b0));
    step(1'b0, 1'b0, 12'h456);
    check("hold2_gray", gray, 12'h00D);
    check("hold2_valid", W'(out_valid), W'(1'b0));

    // random words through the scoreboard
    for (int i = 0; i < 10; i++) begin
      rb = W'($urandom_range(0, 4095));
      exp_q.push_back(rb ^ (rb >> 1));
      step(1'b0, 1'b1, rb);
      e = exp_q.pop_front();
      check($sformatf("rand_gray_%0d", i), gray, e);
      check($sformatf("rand_valid_%0d", i), W'(out_valid), W'(1'b1));
      check_err_clear($sformatf("rand_chk_err_%0d", i));
    end

    // reset on the edge that would capture 0x555
    step(1'b1, 1'b1, 12'h555);
    check("midrst_gray", gray, 12'h000);
    check("midrst_valid", W'(out_valid), W'(1'b0));
    step(1'b0, 1'b1, 12'h555);
    check("after_rst_gray", gray, 12'h7FF);
    check("after_rst_valid", W'(out_valid), W'(1'b1));
    step(1'b0, 1'b0, 12'h000);
    check("final_gray", gray, 12'h7FF);
    check("final_valid", W'(out_valid), W'(1'b0));
    check_err_clear("final_chk_err");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
